// File: rtl/i2s_rx_pkg.sv
// Shared I2S definitions: word-select encoding, default sample width and the stereo packing helper.
`default_nettype none

package i2s_rx_pkg;

  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_e;

  localparam int DEFAULT_SAMPLE_BITS = 16;
  localparam int FRAME_W             = 32;

  // Same packed layout the transmit side pushes into PIO: {left,right}, optionally byte-swapped per half.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [15:0] left,
                                                    input logic [15:0] right,
                                                    input logic        swap);
    if (swap) return {left[7:0], left[15:8], right[7:0], right[15:8]};
    return {left, right};
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_rx_fifo.sv
// Show-ahead synchronous FIFO with pull handshake; drop flags a push refused because the FIFO is full.
`default_nettype none

module i2s_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pull,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = pull & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign wr_ok = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/i2s_rx.sv
// I2S capture receiver: synchronises BCLK/LRCLK/SDATA, deserialises left/right slots and queues
// packed stereo frames in a show-ahead FIFO with sticky overflow and framing-error flags.
`default_nettype none

module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS,
  parameter int FIFO_DEPTH  = 4,
  parameter int BYTE_SWAP   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdata,
  input  logic        pull,
  output logic [31:0] dout,
  output logic        rx_empty,
  output logic        rx_full,
  output logic        overflow,
  output logic        frame_err
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_BITS);

  logic bclk_m, bclk_s, bclk_h;
  logic lr_m, lr_s;
  logic sd_m, sd_s;

  logic                   lr_prev;
  logic                   synced;
  logic                   have_left;
  logic [CW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-1:0] shift;
  logic [SAMPLE_BITS-1:0] left_word;
  logic                   push_req;
  logic [31:0]            push_data;

  logic                   bclk_rise;
  logic                   boundary;
  logic [CW-1:0]          cnt_n;
  logic [SAMPLE_BITS-1:0] shift_n;
  logic                   fifo_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_m <= 1'b0;
      bclk_s <= 1'b0;
      bclk_h <= 1'b0;
      lr_m   <= 1'b0;
      lr_s   <= 1'b0;
      sd_m   <= 1'b0;
      sd_s   <= 1'b0;
    end else begin
      bclk_m <= i2s_bclk;
      bclk_s <= bclk_m;
      bclk_h <= bclk_s;
      lr_m   <= i2s_lrclk;
      lr_s   <= lr_m;
      sd_m   <= i2s_sdata;
      sd_s   <= sd_m;
    end
  end

  assign bclk_rise = bclk_s & ~bclk_h;
  assign boundary  = (lr_s != lr_prev);

  // Bits beyond SAMPLE_BITS in a long slot are ignored; the counter saturates.
  always_comb begin
    shift_n = shift;
    cnt_n   = bit_cnt;
    if (bit_cnt < CNT_MAX) begin
      shift_n = {shift[SAMPLE_BITS-2:0], sd_s};
      cnt_n   = bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_prev   <= 1'b0;
      synced    <= 1'b0;
      have_left <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      left_word <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (fifo_drop) overflow <= 1'b1;

      if (!enable) begin
        synced    <= 1'b0;
        have_left <= 1'b0;
        bit_cnt   <= '0;
        shift     <= '0;
      end else if (bclk_rise) begin
        lr_prev <= lr_s;
        if (!boundary) begin
          shift   <= shift_n;
          bit_cnt <= cnt_n;
        end else begin
          // The boundary rise carries the LSB of the slot that is ending.
          shift   <= '0;
          bit_cnt <= '0;
          if (!synced) begin
            synced <= 1'b1;
          end else if (cnt_n == CNT_MAX) begin
            if (lr_prev == LR_LEFT) begin
              left_word <= shift_n;
              have_left <= 1'b1;
            end else if (have_left) begin
              push_req  <= 1'b1;
              push_data <= pack_frame(16'(left_word), 16'(shift_n), BYTE_SWAP != 0);
              have_left <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            have_left <= 1'b0;
          end
        end
      end
    end
  end

  i2s_rx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_data),
    .pull  (pull),
    .dout  (dout),
    .empty (rx_empty),
    .full  (rx_full),
    .drop  (fifo_drop)
  );

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx: one instance without and one with byte swapping.
`default_nettype none

module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic        pull = 1'b0;
  logic        pull_sw = 1'b0;

  logic [31:0] dout, dout_sw;
  logic        rx_empty, rx_full, overflow, frame_err;
  logic        rx_empty_sw, rx_full_sw, overflow_sw, frame_err_sw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_BITS(16), .FIFO_DEPTH(4), .BYTE_SWAP(0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .pull(pull), .dout(dout), .rx_empty(rx_empty), .rx_full(rx_full),
    .overflow(overflow), .frame_err(frame_err)
  );

  i2s_rx #(.SAMPLE_BITS(16), .FIFO_DEPTH(4), .BYTE_SWAP(1)) dut_sw (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .pull(pull_sw), .dout(dout_sw), .rx_empty(rx_empty_sw), .rx_full(rx_full_sw),
    .overflow(overflow_sw), .frame_err(frame_err_sw)
  );

  // Low phase of 4 clk with data/word-select set, then BCLK rises; returns right at the rise.
  task automatic bit_rise(input logic lr, input logic d);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = lr;
    sdata = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    bit_rise(lr, d);
    repeat (3) @(negedge clk);
  endtask

  // LRCLK flips with the LSB, one bit ahead of the next slot's MSB.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~lr : lr, w[i]);
  endtask

  task automatic send_slot_open(input logic lr, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 1; i--) send_bit(lr, w[i]);
    bit_rise(~lr, w[0]);
  endtask

  task automatic pulse_pull;
    @(negedge clk);
    pull = 1'b1;
    @(negedge clk);
    pull = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h expected %h", dout, 32'h0); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", rx_empty); end
    n_cmp++; if (rx_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", rx_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (rx_empty_sw !== 1'b1) begin n_bad++; $display("FAIL reset_empty_sw: got %b expected 1", rx_empty_sw); end
  endtask

  task automatic test_basic;
    send_slot(1'b0, 32'h0000_5A5A, 7);
    send_slot(1'b1, 32'h0000_ABCD, 16);
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL partial_dropped: rx_empty got %b expected 1", rx_empty); end
    send_slot(1'b0, 32'h0000_1234, 16);
    send_slot_open(1'b1, 32'h0000_ABCD, 16);
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL push_latency_early: rx_empty got %b expected 1", rx_empty); end
    @(negedge clk);
    n_cmp++; if (rx_empty !== 1'b0) begin n_bad++; $display("FAIL push_latency: rx_empty got %b expected 0", rx_empty); end
    n_cmp++; if (dout !== 32'h1234ABCD) begin n_bad++; $display("FAIL basic_dout: got %h expected %h", dout, 32'h1234ABCD); end
    n_cmp++; if (dout_sw !== 32'h3412CDAB) begin n_bad++; $display("FAIL swap_dout: got %h expected %h", dout_sw, 32'h3412CDAB); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL basic_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_byte_swap_pull;
    @(negedge clk);
    pull_sw = 1'b1;
    @(negedge clk);
    pull_sw = 1'b0;
    n_cmp++; if (rx_empty_sw !== 1'b1) begin n_bad++; $display("FAIL swap_pull_empty: got %b expected 1", rx_empty_sw); end
    n_cmp++; if (dout_sw !== 32'h0) begin n_bad++; $display("FAIL swap_pull_dout: got %h expected %h", dout_sw, 32'h0); end
    n_cmp++; if (dout !== 32'h1234ABCD) begin n_bad++; $display("FAIL independent_pull: got %h expected %h", dout, 32'h1234ABCD); end
    pulse_pull;
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL basic_pull_empty: got %b expected 1", rx_empty); end
  endtask

  task automatic test_long_slots;
    send_slot(1'b0, 32'h8001_0000, 32);
    send_slot(1'b1, 32'h8001_0000, 32);
    repeat (2) @(negedge clk);
    n_cmp++; if (dout !== 32'h80018001) begin n_bad++; $display("FAIL long_dout: got %h expected %h", dout, 32'h80018001); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL long_frame_err: got %b expected 0", frame_err); end
    pulse_pull;
  endtask

  task automatic test_frame_err;
    send_slot(1'b0, 32'h0000_1111, 16);
    send_slot(1'b1, 32'h0000_0ABC, 12);
    repeat (2) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_frame_err: got %b expected 1", frame_err); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL short_no_push: rx_empty got %b expected 1", rx_empty); end
    send_slot(1'b0, 32'h0000_0F0F, 16);
    send_slot(1'b1, 32'h0000_F0F0, 16);
    repeat (2) @(negedge clk);
    n_cmp++; if (dout !== 32'h0F0FF0F0) begin n_bad++; $display("FAIL recover_dout: got %h expected %h", dout, 32'h0F0FF0F0); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_sticky: got %b expected 1", frame_err); end
    pulse_pull;
  endtask

  task automatic test_overflow;
    logic [15:0] lw [5] = '{16'h0001, 16'h0003, 16'h0005, 16'h0007, 16'h0009};
    logic [15:0] rw [5] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0010};
    logic [31:0] drain [4] = '{32'h00050006, 32'h00070008, 32'h000B000C, 32'h00000000};
    for (int k = 0; k < 5; k++) begin
      send_slot(1'b0, {16'h0, lw[k]}, 16);
      send_slot(1'b1, {16'h0, rw[k]}, 16);
      if (k == 3) begin
        repeat (2) @(negedge clk);
        n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL four_full: got %b expected 1", rx_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL four_no_overflow: got %b expected 0", overflow); end
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL overflow_full: got %b expected 1", rx_full); end
    n_cmp++; if (dout !== 32'h00010002) begin n_bad++; $display("FAIL overflow_head: got %h expected %h", dout, 32'h00010002); end

    send_slot(1'b0, 32'h0000_000B, 16);
    send_slot_open(1'b1, 32'h0000_000C, 16);
    repeat (2) @(negedge clk);
    @(negedge clk);
    pull = 1'b1;
    @(negedge clk);
    pull = 1'b0;
    n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL pop_push_full: got %b expected 1", rx_full); end
    n_cmp++; if (dout !== 32'h00030004) begin n_bad++; $display("FAIL pop_push_head: got %h expected %h", dout, 32'h00030004); end

    for (int k = 0; k < 4; k++) begin
      pulse_pull;
      n_cmp++; if (dout !== drain[k]) begin n_bad++; $display("FAIL drain_%0d: got %h expected %h", k, dout, drain[k]); end
    end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL drained_empty: got %b expected 1", rx_empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_swap_pull;
    test_long_slots;
    test_frame_err;
    test_overflow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
